// File: rtl/sha_arb_pkg.sv
// Shared constants and state encoding for the SHA-256 core arbiter.
package sha_arb_pkg;

    localparam int ADDR_W             = 16;
    localparam int NUM_REQ_DEF        = 4;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ARB_IDLE      = 3'd0;
    localparam arb_state_t ARB_START     = 3'd1;
    localparam arb_state_t ARB_WAIT_BUSY = 3'd2;
    localparam arb_state_t ARB_WAIT_DONE = 3'd3;
    localparam arb_state_t ARB_RELEASE   = 3'd4;

    // Requester index width; never below one bit.
    function automatic int idx_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sha256_arbiter_if.sv
// Signal bundle between the requesters, the arbiter and the shared SHA-256 core.
interface sha256_arbiter_if
    import sha_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) ();

    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_input_addr;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_hash_addr;
    logic [NUM_REQ-1:0]             grant;
    logic [NUM_REQ-1:0]             req_done;
    logic                           err_timeout;
    logic                           core_start;
    logic [ADDR_W-1:0]              core_input_addr;
    logic [ADDR_W-1:0]              core_hash_addr;
    logic                           core_done;
    logic                           busy;

    // Arbiter side.
    modport slave (
        input  req, req_input_addr, req_hash_addr, core_done,
        output grant, req_done, err_timeout, core_start,
               core_input_addr, core_hash_addr, busy
    );

    // Requester / core-model side.
    modport master (
        output req, req_input_addr, req_hash_addr, core_done,
        input  grant, req_done, err_timeout, core_start,
               core_input_addr, core_hash_addr, busy
    );

endinterface

// File: rtl/sha_rr_pick.sv
// Combinational round-robin pick: first set req bit starting at last_owner+1, wrapping.
module sha_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    localparam int SW = IDX_W + 1;

    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // Candidate gi is the requester gi+1 positions after the previous owner.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [SW-1:0] sum;
        logic [SW-1:0] wrapped;
        assign sum           = {1'b0, last_owner} + SW'(gi + 1);
        assign wrapped       = (sum >= SW'(NUM_REQ)) ? sum - SW'(NUM_REQ) : sum;
        assign cand_idx[gi]  = wrapped[IDX_W-1:0];
        assign hit[gi]       = req[cand_idx[gi]];
    end

    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                valid = 1'b1;
                index = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/sha256_arbiter.sv
// Round-robin arbiter sharing one SHA-256 core among NUM_REQ requesters,
// with latched core addresses and a per-job watchdog.
module sha256_arbiter
    import sha_arb_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    sha256_arbiter_if.slave bus
);

    localparam int              IDX_W    = idx_width(NUM_REQ);
    localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    arb_state_t         state_reg, state_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [IDX_W-1:0]   last_owner_reg, last_owner_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [ADDR_W-1:0]  in_addr_reg, in_addr_next;
    logic [ADDR_W-1:0]  hash_addr_reg, hash_addr_next;
    logic [WD_W-1:0]    wdog_reg, wdog_next;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_index;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               in_wait;
    logic               wdog_expired;

    sha_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (bus.req),
        .last_owner (last_owner_reg),
        .valid      (pick_valid),
        .index      (pick_index)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign pick_onehot[gi] = (pick_index == IDX_W'(gi));
    end

    assign in_wait      = (state_reg == ARB_WAIT_BUSY) || (state_reg == ARB_WAIT_DONE);
    // Expiry outranks a core_done edge arriving in the same cycle.
    assign wdog_expired = in_wait && (wdog_reg == WD_LIMIT);

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        grant_next      = grant_reg;
        in_addr_next    = in_addr_reg;
        hash_addr_next  = hash_addr_reg;
        wdog_next       = wdog_reg;

        case (state_reg)
            ARB_IDLE: begin
                if (bus.core_done && pick_valid) begin
                    owner_next     = pick_index;
                    grant_next     = pick_onehot;
                    in_addr_next   = bus.req_input_addr[pick_index];
                    hash_addr_next = bus.req_hash_addr[pick_index];
                    wdog_next      = '0;
                    state_next     = ARB_START;
                end
            end
            ARB_START: begin
                state_next = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY, ARB_WAIT_DONE: begin
                if (wdog_expired) begin
                    last_owner_next = owner_reg;
                    grant_next      = '0;
                    state_next      = ARB_IDLE;
                end else begin
                    wdog_next = wdog_reg + WD_W'(1);
                    if (state_reg == ARB_WAIT_BUSY && !bus.core_done) begin
                        state_next = ARB_WAIT_DONE;
                    end else if (state_reg == ARB_WAIT_DONE && bus.core_done) begin
                        state_next = ARB_RELEASE;
                    end
                end
            end
            ARB_RELEASE: begin
                last_owner_next = owner_reg;
                grant_next      = '0;
                state_next      = ARB_IDLE;
            end
            default: begin
                grant_next = '0;
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB_IDLE;
            owner_reg      <= '0;
            last_owner_reg <= IDX_W'(NUM_REQ - 1);
            grant_reg      <= '0;
            in_addr_reg    <= '0;
            hash_addr_reg  <= '0;
            wdog_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            grant_reg      <= grant_next;
            in_addr_reg    <= in_addr_next;
            hash_addr_reg  <= hash_addr_next;
            wdog_reg       <= wdog_next;
        end
    end

    // Pulses are state decodes, so reset clears them without waiting for a clock.
    assign bus.grant           = grant_reg;
    assign bus.req_done        = (state_reg == ARB_RELEASE) ? grant_reg : '0;
    assign bus.err_timeout     = wdog_expired;
    assign bus.core_start      = (state_reg == ARB_START);
    assign bus.core_input_addr = in_addr_reg;
    assign bus.core_hash_addr  = hash_addr_reg;
    assign bus.busy            = (state_reg != ARB_IDLE);

endmodule

// File: doc/sha256_arbiter.md
SHA256_ARBITER -- requirements
Module: sha256_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one simplified SHA-256 core (legal range 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the watchdog limit in cycles for one core job.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req  in  NUM_REQ  per-requester job request, level.
REQ-006 req_input_addr  in  NUM_REQ x 16  per-requester message word address.
REQ-007 req_hash_addr  in  NUM_REQ x 16  per-requester hash result word address.
REQ-008 grant  out  NUM_REQ  one-hot owner of the core, all-zero when idle.
REQ-009 req_done  out  NUM_REQ  one-cycle pulse to the owner on job completion.
REQ-010 err_timeout  out  1  one-cycle pulse when a job exceeds TIMEOUT_CYCLES.
REQ-011 core_start  out  1  one-cycle start pulse to the core.
REQ-012 core_input_addr / core_hash_addr  out  16 each  latched addresses of the owner.
REQ-013 core_done  in  1  core idle level (high when core is in IDLE).
REQ-014 busy  out  1  high in every state except ARB_IDLE.

Function
REQ-015 States SHALL be ARB_IDLE, ARB_START, ARB_WAIT_BUSY, ARB_WAIT_DONE, ARB_RELEASE.
REQ-016 ARB_IDLE: when any req bit is high and core_done=1, the arbiter SHALL select the first set req bit searching from (last_owner+1) mod NUM_REQ upward with wrap, latch its index and both addresses, assert grant, and go to ARB_START next cycle.
REQ-017 ARB_IDLE with core_done=0 SHALL grant nothing and remain in ARB_IDLE.
REQ-018 ARB_START: core_start SHALL be 1 for exactly this one cycle; next state ARB_WAIT_BUSY.
REQ-019 ARB_WAIT_BUSY: on core_done=0 go to ARB_WAIT_DONE; otherwise remain.
REQ-020 ARB_WAIT_DONE: on core_done=1 go to ARB_RELEASE.
REQ-021 ARB_RELEASE: req_done[owner] SHALL pulse for this one cycle, last_owner SHALL update to owner, grant SHALL clear on exit, next state ARB_IDLE.
REQ-022 Minimum spacing: a new grant SHALL occur no earlier than the cycle after ARB_RELEASE (no back-to-back overlap of core_start).
REQ-023 core_input_addr/core_hash_addr SHALL hold the latched values from grant through ARB_RELEASE regardless of requester input changes.
REQ-024 An owner dropping req mid-job SHALL NOT abort the job; req_done SHALL still pulse.
REQ-025 A requester holding req high continuously SHALL be re-granted only after every other pending requester has been served once (round-robin fairness).
REQ-026 Watchdog counter, width clog2(TIMEOUT_CYCLES+1), SHALL clear on entry to ARB_START and count each cycle in ARB_WAIT_BUSY/ARB_WAIT_DONE; on reaching TIMEOUT_CYCLES it SHALL pulse err_timeout, suppress req_done, update last_owner, clear grant and return to ARB_IDLE.
REQ-027 A core_done transition in the same cycle as watchdog expiry SHALL be treated as timeout.

Reset
REQ-028 Asserting rst_n low SHALL immediately force state ARB_IDLE, grant=0, req_done=0, err_timeout=0, core_start=0, core addresses=0, watchdog=0, last_owner=NUM_REQ-1 (so requester 0 wins first).
REQ-029 Reset mid-job SHALL discard the job with no req_done pulse; the core is reset by the same rst_n.

Structure
REQ-030 Package sha_arb_pkg SHALL hold the state enum, ADDR_W=16 and default parameter constants.
REQ-031 The round-robin selection SHALL be a combinational sub-module sha_rr_pick (inputs req, last_owner; outputs valid, index).

Verification
REQ-032 Single request: req=0001, core model busy 100 cycles -> core_start one pulse 1 cycle after grant, req_done=0001 pulse after core_done returns high, grant=0 afterwards.
REQ-033 Contention: req=1111 held, core 50 cycles -> grant order 0,1,2,3,0 with one req_done per job.
REQ-034 Address latch: req_input_addr[2]=0x0100, hash_addr[2]=0x0200 granted, inputs changed to 0xFFFF next cycle -> core addresses stay 0x0100/0x0200 until release.
REQ-035 Timeout: TIMEOUT_CYCLES=16, core_done stuck high after start -> err_timeout pulse 16 cycles into wait, no req_done, next requester granted.
REQ-036 Reset mid-job: rst_n low during ARB_WAIT_DONE -> all outputs 0 immediately; after release requester 0 granted first.
REQ-037 Core not idle: core_done=0 with req=0010 -> no grant until core_done=1.
